// File: rtl/otter_cu_decode_pipe_if.sv
// Handshake and control bus for the OTTER registered decode stage.
// The slave modport is the decoder's view; the master modport is the fetch/execute side.
interface otter_cu_decode_pipe_if #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         cu_opcode;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic               br_eq;
    logic               br_lt;
    logic               br_ltu;
    logic [NUM_IRQ-1:0] irq;
    logic               mie;
    logic               out_ready;
    logic               out_valid;
    logic [3:0]         alu_fun;
    logic               alu_srca;
    logic [1:0]         alu_srcb;
    logic [1:0]         rf_wr_sel;
    logic [2:0]         pc_source;
    logic               rf_we;
    logic               mem_we;
    logic               mem_re;
    logic               illegal;
    logic               int_taken;
    logic [CAUSE_W-1:0] int_cause;
    logic               in_handler;

    modport master (
        output in_valid, cu_opcode, func3, func7, br_eq, br_lt, br_ltu, irq, mie, out_ready,
        input  in_ready, out_valid, alu_fun, alu_srca, alu_srcb, rf_wr_sel, pc_source,
               rf_we, mem_we, mem_re, illegal, int_taken, int_cause, in_handler
    );

    modport slave (
        input  in_valid, cu_opcode, func3, func7, br_eq, br_lt, br_ltu, irq, mie, out_ready,
        output in_ready, out_valid, alu_fun, alu_srca, alu_srcb, rf_wr_sel, pc_source,
               rf_we, mem_we, mem_re, illegal, int_taken, int_cause, in_handler
    );
endinterface

// File: rtl/otter_cu_decode_pipe.sv
// Registered RV32I control decoder with edge-detected interrupts and a RUN/HANDLER trap FSM.
// One instruction per accepted transfer; decoded controls appear one cycle later.
module otter_cu_decode_pipe #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = 4
) (
    input logic                     clk,
    input logic                     rst,
    otter_cu_decode_pipe_if.slave   bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [3:0]         alu_fun;
        logic               alu_srca;
        logic [1:0]         alu_srcb;
        logic [1:0]         rf_wr_sel;
        logic [2:0]         pc_source;
        logic               rf_we;
        logic               mem_we;
        logic               mem_re;
        logic               illegal;
        logic               int_taken;
        logic [CAUSE_W-1:0] int_cause;
    } ctrl_t;

    typedef enum logic {RUN, HANDLER} state_t;

    state_t             state;
    state_t             state_next;
    ctrl_t              dec;
    ctrl_t              trap;
    ctrl_t              out_q;
    logic               out_valid;
    logic               accept;
    logic               take;
    logic               is_mret;
    logic               br_take;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] take_mask;
    logic [CAUSE_W-1:0] take_idx;

    assign bus.in_ready = !out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mret      = (bus.cu_opcode == OPC_SYSTEM) && (bus.func3 == 3'b000);
    assign take         = accept && (state == RUN) && bus.mie && (|pending);

    always_comb begin
        dec     = '0;
        br_take = 1'b0;
        case (bus.cu_opcode)
            OPC_LUI: begin
                dec.alu_fun   = 4'd9;
                dec.alu_srca  = 1'b1;
                dec.rf_wr_sel = 2'd3;
                dec.rf_we     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_srca  = 1'b1;
                dec.alu_srcb  = 2'd3;
                dec.rf_wr_sel = 2'd3;
                dec.rf_we     = 1'b1;
            end
            OPC_JAL: begin
                dec.pc_source = 3'd3;
                dec.rf_we     = 1'b1;
            end
            OPC_JALR: begin
                dec.pc_source = 3'd1;
                dec.rf_we     = 1'b1;
            end
            OPC_BRANCH: begin
                case (bus.func3)
                    3'b000:  br_take = bus.br_eq;
                    3'b001:  br_take = !bus.br_eq;
                    3'b100:  br_take = bus.br_lt;
                    3'b101:  br_take = !bus.br_lt;
                    3'b110:  br_take = bus.br_ltu;
                    3'b111:  br_take = !bus.br_ltu;
                    default: dec.illegal = 1'b1;
                endcase
                dec.pc_source = br_take ? 3'd2 : 3'd0;
            end
            OPC_LOAD: begin
                dec.alu_srcb  = 2'd1;
                dec.rf_wr_sel = 2'd2;
                dec.rf_we     = 1'b1;
                dec.mem_re    = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_srcb  = 2'd2;
                dec.mem_we    = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding uses funct7 to pick arithmetic vs logical
                dec.alu_fun   = (bus.func3 == 3'b101) ? {bus.func7[5], bus.func3} : {1'b0, bus.func3};
                dec.alu_srcb  = 2'd1;
                dec.rf_wr_sel = 2'd3;
                dec.rf_we     = 1'b1;
            end
            OPC_OP: begin
                dec.alu_fun   = {bus.func7[5], bus.func3};
                dec.rf_wr_sel = 2'd3;
                dec.rf_we     = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.alu_fun   = 4'd9;
                dec.rf_wr_sel = 2'd1;
                if (bus.func3 == 3'b000) begin
                    dec.pc_source = 3'd5;
                end else begin
                    dec.rf_we     = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Scanning downward leaves the lowest pending line as the winner
    always_comb begin
        take_idx  = '0;
        take_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                take_idx  = CAUSE_W'(i);
                take_mask = '0;
                take_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        trap           = '0;
        trap.int_taken = 1'b1;
        trap.pc_source = 3'd4;
        trap.int_cause = take_idx;
    end

    // A new rising edge outranks the clear of the line being taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= bus.irq;
            pending  <= (pending & ~(take ? take_mask : '0)) | (bus.irq & ~irq_prev);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take) state_next = HANDLER;
            HANDLER: if (accept && is_mret) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        bus.in_handler = (state == HANDLER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= take ? trap : dec;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.alu_fun   = out_q.alu_fun;
    assign bus.alu_srca  = out_q.alu_srca;
    assign bus.alu_srcb  = out_q.alu_srcb;
    assign bus.rf_wr_sel = out_q.rf_wr_sel;
    assign bus.pc_source = out_q.pc_source;
    assign bus.rf_we     = out_q.rf_we;
    assign bus.mem_we    = out_q.mem_we;
    assign bus.mem_re    = out_q.mem_re;
    assign bus.illegal   = out_q.illegal;
    assign bus.int_taken = out_q.int_taken;
    assign bus.int_cause = out_q.int_cause;

endmodule

// File: tb/tb_otter_cu_decode_pipe.sv
// Scoreboard bench for otter_cu_decode_pipe: directed instructions push hand-computed slots,
// a negedge monitor pops and compares every slot the stage hands downstream.
module tb_otter_cu_decode_pipe;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    logic [20:0] sb[$];
    logic [20:0] mon_exp;

    otter_cu_decode_pipe_if #(.NUM_IRQ(4), .CAUSE_W(4)) bus ();

    otter_cu_decode_pipe #(.NUM_IRQ(4), .CAUSE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slot layout: {taken, cause, alu_fun, srca, srcb, rf_wr_sel, pc_source, rf_we, mem_we, mem_re, illegal}
    function automatic logic [20:0] mk(input logic t, input logic [3:0] c, input logic [3:0] alu,
                                       input logic sa, input logic [1:0] sbv, input logic [1:0] sel,
                                       input logic [2:0] pc, input logic we, input logic mwe,
                                       input logic mre, input logic ill);
        return {t, c, alu, sa, sbv, sel, pc, we, mwe, mre, ill};
    endfunction

    function automatic logic [20:0] act();
        return {bus.int_taken, bus.int_cause, bus.alu_fun, bus.alu_srca, bus.alu_srcb, bus.rf_wr_sel,
                bus.pc_source, bus.rf_we, bus.mem_we, bus.mem_re, bus.illegal};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [2:0] flags, input logic [20:0] exp);
        bit accepted = 1'b0;
        bus.cu_opcode = op;
        bus.func3     = f3;
        bus.func7     = f7;
        {bus.br_eq, bus.br_lt, bus.br_ltu} = flags;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (bus.in_ready) begin
                sb.push_back(exp);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            fails++;
            $display("[TB] FAIL send_timeout: opcode 0x%0h never accepted", op);
        end
    endtask

    task automatic pulse_irq(input logic [3:0] mask);
        bus.irq = mask;
        @(posedge clk);
        #1;
        bus.irq = 4'b0000;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_slot: got 0x%0h, expected no slot", act());
            end else begin
                mon_exp = sb.pop_front();
                check_output("slot", {11'd0, act()}, {11'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [20:0] e_load;
        logic [20:0] e_lui;
        logic [20:0] e_mret;
        logic [20:0] e_add;
        checks = 0;
        fails  = 0;
        e_load = mk(0, 4'd0, 4'd0, 0, 2'd1, 2'd2, 3'd0, 1, 0, 1, 0);
        e_lui  = mk(0, 4'd0, 4'd9, 1, 2'd0, 2'd3, 3'd0, 1, 0, 0, 0);
        e_mret = mk(0, 4'd0, 4'd9, 0, 2'd0, 2'd1, 3'd5, 0, 0, 0, 0);
        e_add  = mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd3, 3'd0, 1, 0, 0, 0);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.cu_opcode = 7'd0;
        bus.func3 = 3'd0;
        bus.func7 = 7'd0;
        {bus.br_eq, bus.br_lt, bus.br_ltu} = 3'b000;
        bus.irq = 4'b0000;
        bus.mie = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ctrl", {11'd0, act()}, 32'd0);
        check_output("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("reset_handler", {31'd0, bus.in_handler}, 32'd0);
        rst = 1'b0;
        idle(1);
        check_output("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        apply_stimulus(OPC_OP, 3'b101, 7'b0100000, 3'b000, mk(0, 4'd0, 4'd13, 0, 2'd0, 2'd3, 3'd0, 1, 0, 0, 0));
        check_output("op_sra_valid", {31'd0, bus.out_valid}, 32'd1);
        check_output("op_sra_alu", {28'd0, bus.alu_fun}, 32'd13);

        apply_stimulus(OPC_BRANCH, 3'b101, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd2, 0, 0, 0, 0));
        apply_stimulus(OPC_BRANCH, 3'b101, 7'd0, 3'b010, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        apply_stimulus(OPC_BRANCH, 3'b010, 7'd0, 3'b111, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 1));
        apply_stimulus(OPC_BRANCH, 3'b000, 7'd0, 3'b100, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd2, 0, 0, 0, 0));
        apply_stimulus(OPC_BRANCH, 3'b001, 7'd0, 3'b100, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        apply_stimulus(OPC_BRANCH, 3'b110, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        apply_stimulus(OPC_BRANCH, 3'b111, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd2, 0, 0, 0, 0));
        apply_stimulus(OPC_LUI, 3'b000, 7'd0, 3'b000, e_lui);
        apply_stimulus(OPC_AUIPC, 3'b000, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 1, 2'd3, 2'd3, 3'd0, 1, 0, 0, 0));
        apply_stimulus(OPC_JALR, 3'b000, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd1, 1, 0, 0, 0));
        apply_stimulus(OPC_STORE, 3'b010, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd2, 2'd0, 3'd0, 0, 1, 0, 0));
        apply_stimulus(OPC_OP_IMM, 3'b101, 7'b0100000, 3'b000, mk(0, 4'd0, 4'd13, 0, 2'd1, 2'd3, 3'd0, 1, 0, 0, 0));
        apply_stimulus(OPC_OP_IMM, 3'b000, 7'b0100000, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd1, 2'd3, 3'd0, 1, 0, 0, 0));
        apply_stimulus(OPC_SYSTEM, 3'b001, 7'd0, 3'b000, mk(0, 4'd0, 4'd9, 0, 2'd0, 2'd1, 3'd0, 1, 0, 0, 0));
        apply_stimulus(7'b0000000, 3'b000, 7'd0, 3'b000, mk(0, 4'd0, 4'd0, 0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 1));
        idle(2);

        // Backpressure: a LOAD sits in the stage while a LUI waits at the input
        bus.out_ready = 1'b0;
        apply_stimulus(OPC_LOAD, 3'b010, 7'd0, 3'b000, e_load);
        bus.cu_opcode = OPC_LUI;
        bus.func3 = 3'b000;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_output("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_output("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check_output("stall_frozen", {11'd0, act()}, {11'd0, e_load});
            @(posedge clk);
            #1;
        end
        sb.push_back(e_lui);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_output("after_stall_lui", {11'd0, act()}, {11'd0, e_lui});
        idle(2);

        // Two simultaneous edges: lowest line first, the other survives the handler
        bus.mie = 1'b1;
        pulse_irq(4'b0110);
        apply_stimulus(OPC_JAL, 3'b000, 7'd0, 3'b000, mk(1, 4'd1, 4'd0, 0, 2'd0, 2'd0, 3'd4, 0, 0, 0, 0));
        check_output("trap1_handler", {31'd0, bus.in_handler}, 32'd1);
        apply_stimulus(OPC_SYSTEM, 3'b000, 7'd0, 3'b000, e_mret);
        check_output("mret_handler", {31'd0, bus.in_handler}, 32'd0);
        apply_stimulus(OPC_OP_IMM, 3'b000, 7'd0, 3'b000, mk(1, 4'd2, 4'd0, 0, 2'd0, 2'd0, 3'd4, 0, 0, 0, 0));
        check_output("trap2_handler", {31'd0, bus.in_handler}, 32'd1);
        apply_stimulus(OPC_SYSTEM, 3'b000, 7'd0, 3'b000, e_mret);
        apply_stimulus(OPC_SYSTEM, 3'b000, 7'd0, 3'b000, e_mret);
        check_output("mret_in_run", {31'd0, bus.in_handler}, 32'd0);

        bus.mie = 1'b0;
        pulse_irq(4'b1000);
        apply_stimulus(OPC_OP, 3'b000, 7'd0, 3'b000, e_add);
        check_output("mie_off_handler", {31'd0, bus.in_handler}, 32'd0);
        bus.mie = 1'b1;
        apply_stimulus(OPC_OP, 3'b000, 7'd0, 3'b000, mk(1, 4'd3, 4'd0, 0, 2'd0, 2'd0, 3'd4, 0, 0, 0, 0));
        apply_stimulus(OPC_SYSTEM, 3'b000, 7'd0, 3'b000, e_mret);

        // Reset during a stall inside the handler with line 0 pending
        pulse_irq(4'b0100);
        apply_stimulus(OPC_OP, 3'b000, 7'd0, 3'b000, mk(1, 4'd2, 4'd0, 0, 2'd0, 2'd0, 3'd4, 0, 0, 0, 0));
        pulse_irq(4'b0001);
        idle(2);
        bus.out_ready = 1'b0;
        apply_stimulus(OPC_LOAD, 3'b010, 7'd0, 3'b000, e_load);
        check_output("pre_reset_handler", {31'd0, bus.in_handler}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check_output("midreset_valid", {31'd0, bus.out_valid}, 32'd0);
        check_output("midreset_handler", {31'd0, bus.in_handler}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        apply_stimulus(OPC_OP, 3'b000, 7'd0, 3'b000, e_add);
        check_output("post_reset_no_trap", {31'd0, bus.int_taken}, 32'd0);
        idle(3);
        check_output("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
